// File: rtl/seq_num_gen_pkg.sv
// Shared types and constants for the sequence generator and its range calculator.
package seq_num_gen_pkg;

    typedef enum logic [1:0] {
        MODE_EVEN = 2'b00,
        MODE_ODD  = 2'b01,
        MODE_ALL  = 2'b10,
        MODE_RSVD = 2'b11
    } mode_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    localparam int STEP_PAIR = 2;
    localparam int STEP_ALL  = 1;

endpackage

// File: rtl/seq_bounds_calc.sv
// Combinational range calculator: bottom/top/step/first value and empty-range flag
// for a given mode, direction and inclusive limit.
module seq_bounds_calc
    import seq_num_gen_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [1:0]       mode_i,
    input  logic             dir_i,
    input  logic [WIDTH-1:0] limit_i,
    output logic [WIDTH-1:0] bottom_o,
    output logic [WIDTH-1:0] top_o,
    output logic [WIDTH-1:0] step_o,
    output logic [WIDTH-1:0] first_o,
    output logic             empty_o
);

    mode_e mode;

    always_comb begin
        mode     = mode_e'(mode_i);
        bottom_o = '0;
        top_o    = limit_i & ~WIDTH'(1);
        step_o   = WIDTH'(STEP_PAIR);
        empty_o  = 1'b0;
        // The reserved encoding falls through to the even-number defaults.
        case (mode)
            MODE_ODD: begin
                bottom_o = WIDTH'(1);
                top_o    = limit_i[0] ? limit_i : limit_i - WIDTH'(1);
                empty_o  = (limit_i == '0);
            end
            MODE_ALL: begin
                top_o  = limit_i;
                step_o = WIDTH'(STEP_ALL);
            end
            default: ;
        endcase
        first_o = dir_i ? top_o : bottom_o;
    end

endmodule

// File: rtl/seq_num_gen.sv
// Synchronous even/odd/all sequence generator with up/down wrap-around, delivering
// values over a valid/ready stream.
module seq_num_gen
    import seq_num_gen_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic [1:0]       mode,
    input  logic             dir,
    input  logic [WIDTH-1:0] limit,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             wrap,
    output logic             err
);

    state_e           state_q, state_d;
    logic [1:0]       mode_q, mode_d;
    logic             dir_q, dir_d;
    logic [WIDTH-1:0] limit_q, limit_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             wrap_q, wrap_d;
    logic             err_q, err_d;

    logic             start_acc;
    logic [1:0]       cfg_mode;
    logic             cfg_dir;
    logic [WIDTH-1:0] cfg_limit;
    logic [WIDTH-1:0] bottom, top, step, first;
    logic             empty;
    logic [WIDTH:0]   up_sum, down_floor;

    // An accepted start feeds the calculator directly so the first value is ready
    // one cycle later; otherwise it sees the latched config for wrap decisions.
    assign start_acc = start && !stop;
    assign cfg_mode  = start_acc ? mode  : mode_q;
    assign cfg_dir   = start_acc ? dir   : dir_q;
    assign cfg_limit = start_acc ? limit : limit_q;

    seq_bounds_calc #(.WIDTH(WIDTH)) u_bounds (
        .mode_i  (cfg_mode),
        .dir_i   (cfg_dir),
        .limit_i (cfg_limit),
        .bottom_o(bottom),
        .top_o   (top),
        .step_o  (step),
        .first_o (first),
        .empty_o (empty)
    );

    // One extra bit keeps v+step and bottom+step from overflowing before the compare.
    assign up_sum     = {1'b0, data_q} + {1'b0, step};
    assign down_floor = {1'b0, bottom} + {1'b0, step};

    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q  <= MODE_EVEN;
            dir_q   <= 1'b0;
            limit_q <= '0;
            data_q  <= '0;
            wrap_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            mode_q  <= mode_d;
            dir_q   <= dir_d;
            limit_q <= limit_d;
            data_q  <= data_d;
            wrap_q  <= wrap_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        dir_d   = dir_q;
        limit_d = limit_q;
        data_d  = data_q;
        wrap_d  = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start_acc) begin
                    mode_d  = mode;
                    dir_d   = dir;
                    limit_d = limit;
                    if (empty) begin
                        err_d = 1'b1;
                    end else begin
                        state_d = ST_RUN;
                        data_d  = first;
                    end
                end
            end
            ST_RUN: begin
                if (stop) begin
                    state_d = ST_IDLE;
                end else if (start_acc) begin
                    mode_d  = mode;
                    dir_d   = dir;
                    limit_d = limit;
                    if (empty) begin
                        err_d   = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        data_d = first;
                    end
                end else if (out_ready) begin
                    if (!dir_q) begin
                        if (up_sum > {1'b0, top}) begin
                            data_d = bottom;
                            wrap_d = 1'b1;
                        end else begin
                            data_d = up_sum[WIDTH-1:0];
                        end
                    end else begin
                        if ({1'b0, data_q} < down_floor) begin
                            data_d = top;
                            wrap_d = 1'b1;
                        end else begin
                            data_d = data_q - step;
                        end
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        out_valid = (state_q == ST_RUN);
        out_data  = data_q;
        wrap      = wrap_q;
        err       = err_q;
    end

endmodule

// File: tb/tb_seq_num_gen.sv
// Directed bench for seq_num_gen (WIDTH=4) with hand-computed expected sequences.
module tb_seq_num_gen;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic [1:0] mode = 2'b00;
    logic       dir = 1'b0;
    logic [3:0] limit = 4'd0;
    logic       out_ready = 1'b0;
    logic       out_valid;
    logic [3:0] out_data;
    logic       wrap;
    logic       err;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    seq_num_gen #(.WIDTH(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .stop     (stop),
        .mode     (mode),
        .dir      (dir),
        .limit    (limit),
        .out_ready(out_ready),
        .out_valid(out_valid),
        .out_data (out_data),
        .wrap     (wrap),
        .err      (err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b want=0", out_valid); end
        checks++; if (out_data !== 4'd0) begin errors++; $display("FAIL reset_data got=%0d want=0", out_data); end
        checks++; if (wrap !== 1'b0 || err !== 1'b0) begin errors++; $display("FAIL reset_pulses got wrap=%b err=%b want 0 0", wrap, err); end
        rst = 1'b0;
    endtask

    task automatic test_even_up();
        mode = 2'b00; dir = 1'b0; limit = 4'd15; out_ready = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            checks++; if (out_valid !== 1'b1 || out_data !== 4'(2 * i) || wrap !== 1'b0) begin
                errors++; $display("FAIL even_up[%0d] got v=%b d=%0d w=%b want v=1 d=%0d w=0", i, out_valid, out_data, wrap, 2 * i);
            end
            tick();
        end
        checks++; if (out_data !== 4'd0 || wrap !== 1'b1 || out_valid !== 1'b1) begin errors++; $display("FAIL even_up_wrap got d=%0d w=%b v=%b want d=0 w=1 v=1", out_data, wrap, out_valid); end
        tick();
        checks++; if (out_data !== 4'd2 || wrap !== 1'b0) begin errors++; $display("FAIL even_up_after_wrap got d=%0d w=%b want d=2 w=0", out_data, wrap); end
    endtask

    task automatic test_odd_down();
        logic [3:0] exp_seq [5];
        exp_seq = '{4'd9, 4'd7, 4'd5, 4'd3, 4'd1};
        // Restart from RUN with a new config.
        mode = 2'b01; dir = 1'b1; limit = 4'd9; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            checks++; if (out_data !== exp_seq[i] || wrap !== 1'b0 || out_valid !== 1'b1) begin
                errors++; $display("FAIL odd_down[%0d] got d=%0d w=%b v=%b want d=%0d w=0 v=1", i, out_data, wrap, out_valid, exp_seq[i]);
            end
            tick();
        end
        checks++; if (out_data !== 4'd9 || wrap !== 1'b1) begin errors++; $display("FAIL odd_down_wrap got d=%0d w=%b want d=9 w=1", out_data, wrap); end
        limit = 4'd10; start = 1'b1;
        tick();
        start = 1'b0;
        checks++; if (out_data !== 4'd9 || wrap !== 1'b0) begin errors++; $display("FAIL odd_down_lim10_first got d=%0d w=%b want d=9 w=0", out_data, wrap); end
        tick();
        checks++; if (out_data !== 4'd7) begin errors++; $display("FAIL odd_down_lim10_second got d=%0d want d=7", out_data); end
    endtask

    task automatic test_backpressure();
        mode = 2'b00; dir = 1'b0; limit = 4'd15; out_ready = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        checks++; if (out_data !== 4'd4) begin errors++; $display("FAIL bp_reach4 got d=%0d want d=4", out_data); end
        out_ready = 1'b0;
        // Config changes without start must have no effect while running.
        mode = 2'b01; dir = 1'b1; limit = 4'd3;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (out_data !== 4'd4 || out_valid !== 1'b1) begin
                errors++; $display("FAIL bp_hold[%0d] got d=%0d v=%b want d=4 v=1", i, out_data, out_valid);
            end
        end
        out_ready = 1'b1;
        tick();
        checks++; if (out_data !== 4'd6 || wrap !== 1'b0) begin errors++; $display("FAIL bp_release got d=%0d w=%b want d=6 w=0", out_data, wrap); end
    endtask

    task automatic test_err_and_single();
        stop = 1'b1;
        tick();
        stop = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL stop_to_idle got v=%b want 0", out_valid); end
        mode = 2'b01; dir = 1'b0; limit = 4'd0; start = 1'b1;
        tick();
        start = 1'b0;
        checks++; if (err !== 1'b1 || out_valid !== 1'b0 || wrap !== 1'b0) begin errors++; $display("FAIL err_pulse got e=%b v=%b w=%b want e=1 v=0 w=0", err, out_valid, wrap); end
        tick();
        checks++; if (err !== 1'b0 || out_valid !== 1'b0) begin errors++; $display("FAIL err_one_cycle got e=%b v=%b want e=0 v=0", err, out_valid); end
        mode = 2'b10; limit = 4'd0; start = 1'b1;
        tick();
        start = 1'b0;
        checks++; if (out_data !== 4'd0 || out_valid !== 1'b1 || wrap !== 1'b0) begin errors++; $display("FAIL single_first got d=%0d v=%b w=%b want d=0 v=1 w=0", out_data, out_valid, wrap); end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (out_data !== 4'd0 || wrap !== 1'b1 || err !== 1'b0) begin
                errors++; $display("FAIL single_repeat[%0d] got d=%0d w=%b e=%b want d=0 w=1 e=0", i, out_data, wrap, err);
            end
        end
    endtask

    task automatic test_start_stop();
        stop = 1'b1;
        tick();
        mode = 2'b00; dir = 1'b0; limit = 4'd15; start = 1'b1;
        tick();
        start = 1'b0; stop = 1'b0;
        checks++; if (out_valid !== 1'b0 || err !== 1'b0) begin errors++; $display("FAIL start_stop_idle got v=%b e=%b want v=0 e=0", out_valid, err); end
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL start_stop_stays got v=%b want 0", out_valid); end
        out_ready = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        checks++; if (out_data !== 4'd8 || out_valid !== 1'b1) begin errors++; $display("FAIL run_to_8 got d=%0d v=%b want d=8 v=1", out_data, out_valid); end
        stop = 1'b1;
        tick();
        stop = 1'b0;
        checks++; if (out_valid !== 1'b0 || out_data !== 4'd8) begin errors++; $display("FAIL stop_at_8 got v=%b d=%0d want v=0 d=8", out_valid, out_data); end
    endtask

    task automatic test_rst_mid_run();
        mode = 2'b00; dir = 1'b0; limit = 4'd15; out_ready = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        checks++; if (out_data !== 4'd6) begin errors++; $display("FAIL rst_reach6 got d=%0d want d=6", out_data); end
        rst = 1'b1; start = 1'b1; mode = 2'b01; dir = 1'b1; limit = 4'd9;
        tick();
        rst = 1'b0; start = 1'b0;
        checks++; if (out_valid !== 1'b0 || out_data !== 4'd0 || wrap !== 1'b0 || err !== 1'b0) begin
            errors++; $display("FAIL rst_mid got v=%b d=%0d w=%b e=%b want v=0 d=0 w=0 e=0", out_valid, out_data, wrap, err);
        end
        mode = 2'b00; dir = 1'b0; limit = 4'd15; start = 1'b1;
        tick();
        start = 1'b0;
        checks++; if (out_valid !== 1'b1 || out_data !== 4'd0) begin errors++; $display("FAIL rst_restart got v=%b d=%0d want v=1 d=0", out_valid, out_data); end
        tick();
        checks++; if (out_data !== 4'd2) begin errors++; $display("FAIL rst_restart_next got d=%0d want d=2", out_data); end
    endtask

    initial begin
        test_reset();
        test_even_up();
        test_odd_down();
        test_backpressure();
        test_err_and_single();
        test_start_stop();
        test_rst_mid_run();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
